// File: rtl/codeword_bit_sequencer.sv
// rtl/codeword_bit_sequencer.sv - bit position tracker for runtime-configurable (N,K) codewords
// Holds N/K, walks bit_idx through the data and parity phases, and reports frame completion and aborts.
module codeword_bit_sequencer #(
  parameter int N_MAX   = 127,
  parameter int K_DEF   = 120,
  parameter int CNT_W   = $clog2(N_MAX + 1),
  parameter int FRAME_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               error_flag,
  input  logic               cfg_load,
  input  logic [CNT_W-1:0]   cfg_n,
  input  logic [CNT_W-1:0]   cfg_k,
  output logic [CNT_W-1:0]   bit_idx,
  output logic               in_data,
  output logic               in_parity,
  output logic               last_bit,
  output logic               busy,
  output logic               done,
  output logic               aborted,
  output logic               cfg_err,
  output logic [FRAME_W-1:0] frame_cnt
);

  typedef enum logic [1:0] {IDLE, DATA, PARITY} state_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W:0]   N_MAX_EXT = (CNT_W + 1)'(N_MAX);
  localparam logic [CNT_W:0]   TWO_EXT   = (CNT_W + 1)'(2);

  state_t           state;
  logic [CNT_W-1:0] n_reg;
  logic [CNT_W-1:0] k_reg;
  logic [CNT_W-1:0] last_idx;
  logic [CNT_W-1:0] next_idx;
  logic             cfg_ok;
  logic             cfg_window;

  assign last_idx  = n_reg - ONE;
  assign next_idx  = bit_idx + ONE;
  assign in_data   = bit_idx < k_reg;
  assign in_parity = !in_data;
  assign last_bit  = bit_idx == last_idx;
  assign busy      = state != IDLE;

  // Range checks use one extra bit so the N_MAX bound stays a real compare.
  assign cfg_ok = ({1'b0, cfg_n} >= TWO_EXT) && ({1'b0, cfg_n} <= N_MAX_EXT) &&
                  (cfg_k >= ONE) && (cfg_k <= cfg_n);
  assign cfg_window = (state == IDLE) && !start && !error_flag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bit_idx   <= '0;
      n_reg     <= CNT_W'(N_MAX);
      k_reg     <= CNT_W'(K_DEF);
      frame_cnt <= '0;
      done      <= 1'b0;
      aborted   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      cfg_err <= 1'b0;

      // An abort drops any beat presented in the same cycle.
      if (error_flag) begin
        bit_idx <= '0;
        state   <= IDLE;
        aborted <= 1'b1;
      end else if (start) begin
        if (bit_idx == last_idx) begin
          bit_idx   <= '0;
          state     <= IDLE;
          frame_cnt <= frame_cnt + 1'b1;
          done      <= 1'b1;
        end else begin
          bit_idx <= next_idx;
          state   <= (next_idx >= k_reg) ? PARITY : DATA;
        end
      end

      if (cfg_load) begin
        if (cfg_window && cfg_ok) begin
          n_reg <= cfg_n;
          k_reg <= cfg_k;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_codeword_bit_sequencer.sv
// tb/tb_codeword_bit_sequencer.sv - directed self-checking bench for codeword_bit_sequencer
module tb_codeword_bit_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        error_flag = 1'b0;
  logic        cfg_load = 1'b0;
  logic [6:0]  cfg_n = '0;
  logic [6:0]  cfg_k = '0;
  logic [6:0]  bit_idx;
  logic        in_data;
  logic        in_parity;
  logic        last_bit;
  logic        busy;
  logic        done;
  logic        aborted;
  logic        cfg_err;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_fc = 0;

  codeword_bit_sequencer dut (
    .clk(clk), .rst(rst), .start(start), .error_flag(error_flag),
    .cfg_load(cfg_load), .cfg_n(cfg_n), .cfg_k(cfg_k),
    .bit_idx(bit_idx), .in_data(in_data), .in_parity(in_parity),
    .last_bit(last_bit), .busy(busy), .done(done), .aborted(aborted),
    .cfg_err(cfg_err), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock with the given inputs; outputs are sampled 1ns after the edge.
  task automatic cycle(input bit st, input bit er, input bit ld, input int n, input int k);
    start      = st;
    error_flag = er;
    cfg_load   = ld;
    cfg_n      = n[6:0];
    cfg_k      = k[6:0];
    @(posedge clk);
    #1;
    start = 1'b0; error_flag = 1'b0; cfg_load = 1'b0;
  endtask

  task automatic cfg(input int n, input int k, input bit exp_err);
    cycle(1'b0, 1'b0, 1'b1, n, k);
    check("cfg_err", cfg_err, exp_err);
  endtask

  // Beats from index 'from' up to 'to'-1, optionally with two stall cycles after each.
  task automatic beats(input int n, input int k, input int from, input int to, input bit stall);
    for (int i = from; i < to; i++) begin
      check("bit_idx", bit_idx, i);
      check("in_data", in_data, i < k);
      check("in_parity", in_parity, i >= k);
      check("last_bit", last_bit, i == n - 1);
      check("busy", busy, i != 0);
      cycle(1'b1, 1'b0, 1'b0, 0, 0);
      if (i == n - 1) begin
        exp_fc++;
        check("done_pulse", done, 1);
        check("frame_cnt", frame_cnt, exp_fc);
        check("idx_wrap", bit_idx, 0);
        check("busy_end", busy, 0);
      end else begin
        check("done_low", done, 0);
      end
      if (stall) begin
        for (int s = 0; s < 2; s++) begin
          cycle(1'b0, 1'b0, 1'b0, 0, 0);
          check("stall_idx", bit_idx, (i == n - 1) ? 0 : i + 1);
          check("stall_done", done, 0);
        end
      end
    end
  endtask

  initial begin
    // 1: reset state and one default 127/120 frame
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    check("rst_idx", bit_idx, 0);
    check("rst_busy", busy, 0);
    check("rst_fc", frame_cnt, 0);
    check("rst_done", done, 0);
    check("rst_abort", aborted, 0);
    check("rst_cfgerr", cfg_err, 0);
    beats(127, 120, 0, 127, 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    check("done_one_cycle", done, 0);

    // 2: three back-to-back frames with start held
    for (int f = 0; f < 3; f++) beats(127, 120, 0, 127, 1'b0);
    check("fc_after_b2b", frame_cnt, 4);

    // 3: runtime config, rejects, and K==N
    cfg(15, 11, 1'b0);
    beats(15, 11, 0, 15, 1'b0);
    cfg(128, 11, 1'b1);
    cfg(15, 0, 1'b1);
    cfg(15, 16, 1'b1);
    beats(15, 11, 0, 15, 1'b0);
    cfg(7, 7, 1'b0);
    beats(7, 7, 0, 7, 1'b0);

    // 4: default config with stall pattern 1,0,0
    cfg(127, 120, 1'b0);
    beats(127, 120, 0, 127, 1'b1);

    // 5: aborts mid-frame and on the final beat
    beats(127, 120, 0, 60, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0);
    check("abort60_pulse", aborted, 1);
    check("abort60_idx", bit_idx, 0);
    check("abort60_busy", busy, 0);
    check("abort60_fc", frame_cnt, exp_fc);
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    check("abort_one_cycle", aborted, 0);
    beats(127, 120, 0, 126, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 0, 0);
    check("abort126_pulse", aborted, 1);
    check("abort126_done", done, 0);
    check("abort126_fc", frame_cnt, exp_fc);
    check("abort126_idx", bit_idx, 0);

    // 6: reset mid-frame restores defaults; cfg_load while busy is rejected
    cfg(15, 11, 1'b0);
    beats(15, 11, 0, 10, 1'b0);
    rst = 1'b1;
    cycle(1'b0, 1'b0, 1'b0, 0, 0);
    rst = 1'b0;
    exp_fc = 0;
    check("rst2_idx", bit_idx, 0);
    check("rst2_fc", frame_cnt, 0);
    check("rst2_busy", busy, 0);
    check("rst2_pulses", {done, aborted, cfg_err}, 0);
    beats(127, 120, 0, 5, 1'b0);
    cfg(15, 11, 1'b1);
    beats(127, 120, 5, 127, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 0 expected 1");
    $fatal(1);
  end

endmodule
